// File: rtl/cskip_adder_pipe_pkg.sv
// cskip_pkg: shared constants and helpers for the pipelined carry-skip adder.
//   DEF_WIDTH / DEF_BLK : default operand width and block size
//   nblk_f()            : number of blocks (= pipeline depth)
//   cfg_ok_f()          : legality of a WIDTH/BLK pair, checked at elaboration
package cskip_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_BLK   = 4;

  function automatic int nblk_f(input int width, input int blk);
    return (blk > 0) ? width / blk : 0;
  endfunction

  function automatic bit cfg_ok_f(input int width, input int blk);
    return (blk >= 1) && (width >= blk) && (width % blk == 0);
  endfunction
endpackage

// File: rtl/cskip_adder_pipe_if.sv
// Handshake/data bundle for cskip_adder_pipe.
//   in_valid/in_ready  : operand handshake (a, b, cin)
//   out_valid/out_ready: result handshake (sum, cout, skip_mask[, ovf])
//   slave  modport: the adder;  master modport: the producer/consumer side.
// ovf exists only when CSKIP_OVF_EN is defined.
interface cskip_adder_pipe_if
  import cskip_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NBLK  = nblk_f(DEF_WIDTH, DEF_BLK)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [NBLK-1:0]  skip_mask;
`ifdef CSKIP_OVF_EN
  logic             ovf;
`endif

  modport slave (
    input  in_valid, a, b, cin, out_ready,
`ifdef CSKIP_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, sum, cout, skip_mask
  );

  modport master (
    output in_valid, a, b, cin, out_ready,
`ifdef CSKIP_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, sum, cout, skip_mask
  );
endinterface

// File: rtl/cskip_adder_pipe_block.sv
// cskip_block: one combinational carry-skip block of BLK bits.
//   a, b : operand slices     cin  : carry into the block
//   s    : sum slice          cout : block carry-out
//   skip : 1 when every bit propagates, so cout is taken straight from cin
module cskip_block #(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           cin,
  output logic [BLK-1:0] s,
  output logic           cout,
  output logic           skip
);
  logic [BLK-1:0] p, g;
  logic [BLK:0]   c;

  assign p    = a ^ b;
  assign g    = a & b;
  assign c[0] = cin;

  for (genvar i = 0; i < BLK; i++) begin : g_rip
    assign c[i+1] = g[i] | (p[i] & c[i]);
    assign s[i]   = p[i] ^ c[i];
  end

  // All-propagate block: the ripple result equals cin, so bypass the chain.
  assign skip = &p;
  assign cout = skip ? cin : c[BLK];
endmodule

// File: rtl/cskip_adder_pipe.sv
// cskip_adder_pipe: pipelined carry-skip adder, one BLK-bit block per stage.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   io (slave) : in_valid/in_ready + a, b, cin ; out_valid/out_ready + sum,
//                cout, skip_mask (bit k = block k carried via skip path)
// Optional: CSKIP_OVF_EN adds io.ovf, signed overflow pipelined with the sum.
// Latency NBLK cycles, one result per cycle; the whole pipe stalls together
// when the output is valid and not accepted.
module cskip_adder_pipe
  import cskip_pkg::*;
#(
  parameter int  WIDTH = DEF_WIDTH,
  parameter int  BLK   = DEF_BLK,
  localparam int NBLK  = nblk_f(WIDTH, BLK)
) (
  input  logic              clk,
  input  logic              rst_n,
  cskip_adder_pipe_if.slave io
);
  if (!cfg_ok_f(WIDTH, BLK)) begin : g_cfg_chk
    $error("cskip_adder_pipe: WIDTH (%0d) must be a positive multiple of BLK (%0d)", WIDTH, BLK);
  end

  logic            adv;
  logic [NBLK-1:0] vld_pipe;   // vld_pipe[k]: stage k register holds a result

  assign adv          = io.out_ready | ~vld_pipe[NBLK-1];
  assign io.in_ready  = adv;
  assign io.out_valid = vld_pipe[NBLK-1];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)   vld_pipe <= '0;
    else if (adv) vld_pipe <= NBLK'({vld_pipe, io.in_valid});

  for (genvar k = 0; k < NBLK; k++) begin : g_stg
    // Operand bits above this block still waiting to be summed.
    localparam int HI = WIDTH - (k+1)*BLK;

    logic [BLK-1:0]       a_blk, b_blk, s_blk;
    logic                 c_in, c_out, skp;
    logic [(k+1)*BLK-1:0] s_q;   // sum bits produced so far
    logic [k:0]           m_q;   // skip bits produced so far
    logic                 c_q;

    if (k == 0) begin : g_src
      assign a_blk = io.a[BLK-1:0];
      assign b_blk = io.b[BLK-1:0];
      assign c_in  = io.cin;
    end else begin : g_src
      assign a_blk = g_stg[k-1].g_hi.a_q[BLK-1:0];
      assign b_blk = g_stg[k-1].g_hi.b_q[BLK-1:0];
      assign c_in  = g_stg[k-1].c_q;
    end

    cskip_block #(.BLK(BLK)) u_blk (
      .a    (a_blk),
      .b    (b_blk),
      .cin  (c_in),
      .s    (s_blk),
      .cout (c_out),
      .skip (skp)
    );

    if (k == 0) begin : g_acc
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          s_q <= '0;
          m_q <= '0;
          c_q <= 1'b0;
        end else if (adv) begin
          s_q <= s_blk;
          m_q <= skp;
          c_q <= c_out;
        end
    end else begin : g_acc
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          s_q <= '0;
          m_q <= '0;
          c_q <= 1'b0;
        end else if (adv) begin
          s_q <= {s_blk, g_stg[k-1].s_q};
          m_q <= {skp, g_stg[k-1].m_q};
          c_q <= c_out;
        end
    end

    // Forward the untouched upper operand bits; the last stage has none.
    if (HI > 0) begin : g_hi
      logic [HI-1:0] a_nx, b_nx, a_q, b_q;
      if (k == 0) begin : g_nx
        assign a_nx = io.a[WIDTH-1:BLK];
        assign b_nx = io.b[WIDTH-1:BLK];
      end else begin : g_nx
        assign a_nx = g_stg[k-1].g_hi.a_q[WIDTH-k*BLK-1:BLK];
        assign b_nx = g_stg[k-1].g_hi.b_q[WIDTH-k*BLK-1:BLK];
      end
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_nx;
          b_q <= b_nx;
        end
    end

`ifdef CSKIP_OVF_EN
    // Carry into the MSB is recovered from the MSB sum bit: c = s ^ a ^ b.
    if (k == NBLK-1) begin : g_ovf
      logic ovf_q;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)   ovf_q <= 1'b0;
        else if (adv) ovf_q <= s_blk[BLK-1] ^ a_blk[BLK-1] ^ b_blk[BLK-1] ^ c_out;
    end
`endif
  end

  assign io.sum       = g_stg[NBLK-1].s_q;
  assign io.cout      = g_stg[NBLK-1].c_q;
  assign io.skip_mask = g_stg[NBLK-1].m_q;
`ifdef CSKIP_OVF_EN
  assign io.ovf       = g_stg[NBLK-1].g_ovf.ovf_q;
`endif
endmodule
